// File: rtl/tt_ctrl_pkg.sv
// Shared definitions for the TinyTapeStation controller-input path:
// FSM state encoding, button bit positions and default timing values.
package tt_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

  // Bit positions in the serial stream and in the button vector
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // 6 us half-phase and ~60 Hz polling at a 25 MHz system clock
  localparam int DEFAULT_CLK_DIV     = 150;
  localparam int DEFAULT_POLL_CYCLES = 416667;

  // Opposing directions pressed together cancel out; face buttons pass through.
  function automatic logic [7:0] socd_clean(input logic [7:0] raw);
    logic [7:0] res;
    res = raw;
    if (raw[BTN_UP] && raw[BTN_DOWN]) begin
      res[BTN_UP]   = 1'b0;
      res[BTN_DOWN] = 1'b0;
    end else begin
      res = res;
    end
    if (raw[BTN_LEFT] && raw[BTN_RIGHT]) begin
      res[BTN_LEFT]  = 1'b0;
      res[BTN_RIGHT] = 1'b0;
    end else begin
      res = res;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the controller data line. Resets to 1, the
// released level of the active-low controller output.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Double-register the asynchronous input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/nes_controller_reader.sv
// NES-style serial gamepad reader. Periodically latches the controller,
// clocks out 8 bits (A first, right last) and presents registered,
// active-high button levels with a one-cycle valid pulse per frame.
// Optional build macro SOCD_CLEAN_EN cancels opposing directions.
module nes_controller_reader
  import tt_ctrl_pkg::*;
#(
  parameter int CLK_DIV     = DEFAULT_CLK_DIV,
  parameter int POLL_CYCLES = DEFAULT_POLL_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic ctrl_data,
  output logic ctrl_latch,
  output logic ctrl_clk,
  output logic A,
  output logic B,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic buttons_valid
);

  localparam int PH_W   = $clog2(2 * CLK_DIV);
  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  localparam logic [PH_W-1:0]   LATCH_END = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]   HALF_END  = PH_W'(CLK_DIV - 1);
  localparam logic [POLL_W-1:0] POLL_END  = POLL_W'(POLL_CYCLES - 1);

  ctrl_state_t       state_r;
  logic [POLL_W-1:0] poll_r;
  logic [PH_W-1:0]   phase_r;
  logic [2:0]        idx_r;
  logic [7:0]        shift_r;
  logic [7:0]        shift_nxt_s;
  logic [7:0]        load_s;
  logic [7:0]        buttons_r;
  logic              data_sync_s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ctrl_data),
    .q     (data_sync_s)
  );

  // Shift register contents including the bit being sampled this cycle
  always_comb begin
    shift_nxt_s        = shift_r;
    shift_nxt_s[idx_r] = data_sync_s;
  end

  // Button word to load: wire bits are active-low, outputs active-high
  always_comb begin
`ifdef SOCD_CLEAN_EN
    load_s = socd_clean(~shift_nxt_s);
`else
    load_s = ~shift_nxt_s;
`endif
  end

  // Frame sequencer: poll timer, latch/clock generation, bit capture, output load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      poll_r        <= '0;
      phase_r       <= '0;
      idx_r         <= 3'd0;
      shift_r       <= 8'hFF;
      buttons_r     <= 8'h00;
      buttons_valid <= 1'b0;
      ctrl_latch    <= 1'b0;
      ctrl_clk      <= 1'b0;
    end else begin
      buttons_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (poll_r == POLL_END) begin
            poll_r     <= '0;
            ctrl_latch <= 1'b1;
            state_r    <= ST_LATCH;
          end else begin
            poll_r <= poll_r + POLL_W'(1);
          end
        end
        ST_LATCH: begin
          if (phase_r == LATCH_END) begin
            phase_r    <= '0;
            idx_r      <= 3'd0;
            ctrl_latch <= 1'b0;
            state_r    <= ST_LOW;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_LOW: begin
          if (phase_r == HALF_END) begin
            phase_r <= '0;
            shift_r <= shift_nxt_s;
            if (idx_r == 3'd7) begin
              // Outputs are loaded on entry so they are visible during DONE
              buttons_r     <= load_s;
              buttons_valid <= 1'b1;
              state_r       <= ST_DONE;
            end else begin
              idx_r    <= idx_r + 3'd1;
              ctrl_clk <= 1'b1;
              state_r  <= ST_HIGH;
            end
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_HIGH: begin
          if (phase_r == HALF_END) begin
            phase_r  <= '0;
            ctrl_clk <= 1'b0;
            state_r  <= ST_LOW;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          poll_r     <= '0;
          phase_r    <= '0;
          ctrl_latch <= 1'b0;
          ctrl_clk   <= 1'b0;
        end
      endcase
    end
  end

  assign A      = buttons_r[BTN_A];
  assign B      = buttons_r[BTN_B];
  assign select = buttons_r[BTN_SELECT];
  assign start  = buttons_r[BTN_START];
  assign up     = buttons_r[BTN_UP];
  assign down   = buttons_r[BTN_DOWN];
  assign left   = buttons_r[BTN_LEFT];
  assign right  = buttons_r[BTN_RIGHT];

endmodule

// File: doc/nes_controller_reader.md
# nes_controller_reader

Serial gamepad front-end for TinyTapeStation. It periodically latches an NES-style parallel-in/serial-out controller, clocks out its 8 button bits, and presents them as registered, active-high button levels. Its outputs feed the player logic's `A, B, select, start, up, down, left, right` inputs directly. It is the producer end of the controller-input interface that the player logic consumes.

## Interface
- `CLK_DIV`, default 150: system cycles per controller half-phase (6 µs at 25 MHz). Must be ≥ 4.
- `POLL_CYCLES`, default 416667: IDLE cycles between frames (≈60 Hz at 25 MHz).
- `clk`, input, 1: system clock.
- `reset`, input, 1: **asynchronous, active-low** reset.
- `ctrl_data`, input, 1: serial data from the controller, active-low button, asynchronous to `clk`.
- `ctrl_latch`, output, 1: parallel-load strobe to the controller, active-high, registered.
- `ctrl_clk`, output, 1: shift clock to the controller, idles low, registered.
- `A, B, select, start, up, down, left, right`, output, 1 each: button levels, 1 = pressed, held between frames.
- `buttons_valid`, output, 1: one-cycle pulse coincident with a button update.

## Operation
- `ctrl_data` passes through a 2-flop synchronizer before any use.
- Bit order on the wire: bit0 = A, then B, select, start, up, down, left, right (bit7).
- States:
  - **IDLE**: the poll counter counts up. When it reaches `POLL_CYCLES-1`, the counter clears and the block goes to LATCH.
  - **LATCH**: `ctrl_latch`=1 for 2·`CLK_DIV` cycles, then the bit index is set to 0 and the block goes to LOW.
  - **LOW**: `ctrl_latch`=0 and `ctrl_clk`=0 for `CLK_DIV` cycles. On the last cycle, the synchronized data is captured into shift bit[index]. If index=7, go to DONE. Otherwise increment the index and go to HIGH.
  - **HIGH**: `ctrl_clk`=1 for `CLK_DIV` cycles, then go to LOW.
  - **DONE**: the button registers load the inverted shift register. `buttons_valid`=1 for this one cycle. Return to IDLE.
- A floating or disconnected controller reads all 1s, so all buttons report released. This is not an error.
- Button outputs change only in DONE.
- Phase counter width: clog2(2·`CLK_DIV`). Poll counter width: clog2(`POLL_CYCLES`). Neither counter wraps; each clears on its state exit.

## Timing
- Reset values: all button outputs 0, `buttons_valid` 0, `ctrl_latch` 0, `ctrl_clk` 0. After reset the block is in IDLE with the poll counter at 0.
- The first `ctrl_latch` rise occurs `POLL_CYCLES` cycles after `reset` deasserts.
- Frame length from latch rise to the DONE cycle: 2D + D + 7·2D = 17·`CLK_DIV` cycles, then 1 DONE cycle.
- Frame start-to-start period: `POLL_CYCLES` + 17·`CLK_DIV` + 1 cycles.
- Exactly 7 `ctrl_clk` high pulses per frame, each `CLK_DIV` cycles wide.
- Sample point is `CLK_DIV` cycles after the preceding edge. With `CLK_DIV` ≥ 4 this covers the synchronizer latency plus controller settle time.
- Reset asserted mid-frame: `ctrl_latch` and `ctrl_clk` drop asynchronously, buttons clear to 0, and no `buttons_valid` pulse is produced. The next frame follows the normal post-reset timing.
- `ctrl_data` changes outside a sample cycle have no effect.

## Configuration
- `SOCD_CLEAN_EN` defined: applied in DONE before loading the button registers.
  - up and down both pressed → both report 0.
  - left and right both pressed → both report 0.
  - A, B, select and start are unaffected.
- `SOCD_CLEAN_EN` undefined: raw inverted bits are loaded unchanged.

## Structure
- Shared package `tt_ctrl_pkg` holds:
  - state encoding (IDLE, LATCH, LOW, HIGH, DONE);
  - button index constants `BTN_A`=0 … `BTN_RIGHT`=7;
  - default `CLK_DIV` and `POLL_CYCLES` values.
- One sub-module: `sync_2ff` (2-flop synchronizer, async active-low reset to 1, i.e. the released level).
- FSM, counters, shift register and output registers are in the top block.

## Test plan
All scenarios use `CLK_DIV`=4 and `POLL_CYCLES`=32.
- Reset release → all outputs 0. `ctrl_latch` rises at cycle 32 and stays high 8 cycles. 7 `ctrl_clk` pulses, each 4 cycles wide. `buttons_valid` pulses at cycle 32+68.
- Controller model presses A and right (wire sequence 0,1,1,1,1,1,1,0) → `A`=1, `right`=1, all others 0, one-cycle `buttons_valid`.
- `ctrl_data` tied 1 → after the frame all buttons 0 and `buttons_valid` still pulses.
- up+down+left pressed:
  - with `SOCD_CLEAN_EN`: `up`=0, `down`=0, `left`=1;
  - without it: all three 1.
- `reset` asserted during the 4th HIGH phase → `ctrl_clk` and `ctrl_latch` go to 0 immediately and no `buttons_valid` pulse occurs. After release, the next frame starts 32 cycles later and reads correctly.
- Model changes the pressed buttons during IDLE → outputs hold their previous values until the next DONE cycle.
